// File: rtl/snn_ecg_pkg.sv
// snn_ecg_pkg: shared defaults, vote FSM state encoding and the saturating-increment helper
package snn_ecg_pkg;
  localparam int N_CLASS_DEF = 5;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v >= mx) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/snn_ecg_vote_cnt.sv
// spike_cnt_bank: N_CLASS saturating spike counters (clk, rst_n async low, clr, inc_en, inc_bits in; cnt_flat out)
module spike_cnt_bank import snn_ecg_pkg::*; #(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc_en,
  input  logic [N_CLASS-1:0]       inc_bits,
  output logic [N_CLASS*CNT_W-1:0] cnt_flat
);
  logic [CNT_W-1:0] cnt_q [N_CLASS];
  logic [CNT_W-1:0] cnt_d [N_CLASS];
  always_comb begin
    for (int k = 0; k < N_CLASS; k++) begin
      cnt_d[k] = clr ? '0 : (inc_en && inc_bits[k]) ? CNT_W'(sat_inc(32'(cnt_q[k]), CNT_W)) : cnt_q[k];
      cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
endmodule

// File: rtl/snn_ecg_vote.sv
// snn_ecg_vote: windowed spike vote + sequential argmax over SNN outputs (clk, rst_n, win_start, net_done, net_spikes in; busy, step_cnt, class_valid, class_idx, class_cnt, no_spike, low_conf out; SNN_VOTE_MARGIN_EN enables low_conf)
module snn_ecg_vote import snn_ecg_pkg::*; #(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int NUM_STEPS = 16,
  parameter int CNT_W = CNT_W_DEF,
  parameter int MARGIN = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           win_start,
  input  logic                           net_done,
  input  logic [N_CLASS-1:0]             net_spikes,
  output logic                           busy,
  output logic [$clog2(NUM_STEPS+1)-1:0] step_cnt,
  output logic                           class_valid,
  output logic [$clog2(N_CLASS)-1:0]     class_idx,
  output logic [CNT_W-1:0]               class_cnt,
  output logic                           no_spike,
  output logic                           low_conf
);
  localparam int SW = $clog2(NUM_STEPS + 1);
  localparam int IW = $clog2(N_CLASS);
  localparam logic [SW-1:0] STEP_LAST = SW'(NUM_STEPS);
  localparam logic [IW-1:0] PTR_LAST = IW'(N_CLASS - 1);
  state_t state_q, state_d;
  logic d_q, step_evt;
  logic [SW-1:0] step_q, step_d;
  logic [IW-1:0] ptr_q, ptr_d, best_i_q, best_i_d, idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d, res_q, res_d, cur;
  logic ns_q, ns_d;
  logic [N_CLASS*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0] cnt_a [N_CLASS];
`ifdef SNN_VOTE_MARGIN_EN
  localparam logic [CNT_W:0] MG = (CNT_W+1)'(MARGIN);
  logic [CNT_W-1:0] second_q, second_d;
  logic lc_q, lc_d, lc_now;
  assign lc_now = ({1'b0, best_q} - {1'b0, second_q}) < MG;
  assign low_conf = class_valid ? lc_now : lc_q;
`else
  assign low_conf = 1'b0;
`endif
  assign step_evt = net_done & ~d_q;
  spike_cnt_bank #(.N_CLASS(N_CLASS), .CNT_W(CNT_W)) u_bank (
    .clk(clk),
    .rst_n(rst_n),
    .clr(win_start),
    .inc_en(state_q == ACCUM && step_evt && !win_start),
    .inc_bits(net_spikes),
    .cnt_flat(cnt_flat)
  );
  always_comb begin
    for (int k = 0; k < N_CLASS; k++) cnt_a[k] = cnt_flat[k*CNT_W +: CNT_W];
  end
  assign cur = cnt_a[ptr_q];
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    ptr_d = ptr_q;
    best_d = best_q;
    best_i_d = best_i_q;
    idx_d = idx_q;
    res_d = res_q;
    ns_d = ns_q;
`ifdef SNN_VOTE_MARGIN_EN
    second_d = second_q;
    lc_d = lc_q;
`endif
    if (win_start) begin
      state_d = ACCUM;
      step_d = '0;
    end else begin
      case (state_q)
        ACCUM: if (step_evt) begin
          step_d = step_q + 1'b1;
          if (step_d == STEP_LAST) begin
            state_d = ARGMAX;
            ptr_d = '0;
            best_d = '0;
            best_i_d = '0;
`ifdef SNN_VOTE_MARGIN_EN
            second_d = '0;
`endif
          end
        end
        ARGMAX: begin
          best_d = (cur > best_q) ? cur : best_q;
          best_i_d = (cur > best_q) ? ptr_q : best_i_q;
`ifdef SNN_VOTE_MARGIN_EN
          second_d = (cur > best_q) ? best_q : (cur > second_q) ? cur : second_q;
`endif
          ptr_d = ptr_q + 1'b1;
          state_d = (ptr_q == PTR_LAST) ? DONE : ARGMAX;
        end
        DONE: begin
          state_d = IDLE;
          idx_d = best_i_q;
          res_d = best_q;
          ns_d = best_q == '0;
`ifdef SNN_VOTE_MARGIN_EN
          lc_d = lc_now;
`endif
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q <= 1'b0;
      step_q <= '0;
      ptr_q <= '0;
      best_q <= '0;
      best_i_q <= '0;
      idx_q <= '0;
      res_q <= '0;
      ns_q <= 1'b0;
`ifdef SNN_VOTE_MARGIN_EN
      second_q <= '0;
      lc_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q <= net_done;
      step_q <= step_d;
      ptr_q <= ptr_d;
      best_q <= best_d;
      best_i_q <= best_i_d;
      idx_q <= idx_d;
      res_q <= res_d;
      ns_q <= ns_d;
`ifdef SNN_VOTE_MARGIN_EN
      second_q <= second_d;
      lc_q <= lc_d;
`endif
    end
  end
  // During the DONE cycle the result is shown straight from the argmax registers; it is latched for holding afterwards.
  assign busy = state_q == ACCUM || state_q == ARGMAX;
  assign step_cnt = step_q;
  assign class_valid = state_q == DONE && !win_start;
  assign class_idx = class_valid ? best_i_q : idx_q;
  assign class_cnt = class_valid ? best_q : res_q;
  assign no_spike = class_valid ? best_q == '0 : ns_q;
endmodule

// File: tb/tb_snn_ecg_vote.sv
// tb_snn_ecg_vote: directed self-checking bench for snn_ecg_vote (NUM_STEPS=4 main instance, CNT_W=2/NUM_STEPS=6 saturation instance)
module tb_snn_ecg_vote;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
`ifdef SNN_VOTE_MARGIN_EN
  localparam int MEN = 1;
`else
  localparam int MEN = 0;
`endif
  logic ws_a = 1'b0, nd_a = 1'b0;
  logic [4:0] sp_a = '0;
  logic busy_a, cv_a, ns_a, lc_a;
  logic [2:0] step_a, idx_a;
  logic [7:0] cnt_a;
  logic ws_b = 1'b0, nd_b = 1'b0;
  logic [4:0] sp_b = '0;
  logic busy_b, cv_b, ns_b, lc_b;
  logic [2:0] step_b, idx_b;
  logic [1:0] cnt_b;
  int n_chk = 0, n_fail = 0, vc_a = 0, vc_b = 0;
  snn_ecg_vote #(.N_CLASS(5), .NUM_STEPS(4), .CNT_W(8), .MARGIN(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .win_start(ws_a), .net_done(nd_a), .net_spikes(sp_a),
    .busy(busy_a), .step_cnt(step_a), .class_valid(cv_a), .class_idx(idx_a),
    .class_cnt(cnt_a), .no_spike(ns_a), .low_conf(lc_a)
  );
  snn_ecg_vote #(.N_CLASS(5), .NUM_STEPS(6), .CNT_W(2), .MARGIN(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .win_start(ws_b), .net_done(nd_b), .net_spikes(sp_b),
    .busy(busy_b), .step_cnt(step_b), .class_valid(cv_b), .class_idx(idx_b),
    .class_cnt(cnt_b), .no_spike(ns_b), .low_conf(lc_b)
  );
  always @(negedge clk) begin
    if (cv_a) vc_a++;
    if (cv_b) vc_b++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step_a_t(input logic [4:0] s);
    nd_a = 1'b1; sp_a = s; tick;
    nd_a = 1'b0; tick;
  endtask
  task automatic step_b_t(input logic [4:0] s);
    nd_b = 1'b1; sp_b = s; tick;
    nd_b = 1'b0; tick;
  endtask
  task automatic win_a(input string tag, input bit do_start, input logic [4:0] s0, s1, s2, s3,
                       input int ei, ec, en, el);
    int n, v0;
    if (do_start) begin
      ws_a = 1'b1; tick; ws_a = 1'b0;
    end
    step_a_t(s0); step_a_t(s1); step_a_t(s2);
    v0 = vc_a;
    nd_a = 1'b1; sp_a = s3; n = 0;
    do begin
      tick; nd_a = 1'b0; n++;
    end while (!cv_a && n < 20);
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_idx"}, idx_a, ei);
    chk({tag, "_cnt"}, cnt_a, ec);
    chk({tag, "_no_spike"}, ns_a, en);
    chk({tag, "_low_conf"}, lc_a, el);
    chk({tag, "_busy_done"}, busy_a, 0);
    tick;
    chk({tag, "_pulse"}, cv_a, 0);
    chk({tag, "_idx_hold"}, idx_a, ei);
    chk({tag, "_cnt_hold"}, cnt_a, ec);
    chk({tag, "_valid_count"}, vc_a - v0, 1);
  endtask
  initial begin
    int v0, n;
    repeat (3) tick;
    chk("rst_busy", busy_a, 0);
    chk("rst_step", step_a, 0);
    chk("rst_valid", cv_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_no_spike", ns_a, 0);
    chk("rst_low_conf", lc_a, 0);
    rst_n = 1'b1;
    tick;
    win_a("t1", 1, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 2, 4, 0, 0);
    win_a("tie", 1, 5'b01010, 5'b01010, 5'b01010, 5'b00001, 1, 3, 0, MEN);
    win_a("zero", 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, MEN);
    win_a("c4", 1, 5'b10000, 5'b10000, 5'b10001, 5'b11000, 4, 4, 0, 0);
    win_a("diff1", 1, 5'b10000, 5'b11000, 5'b01001, 5'b10001, 4, 3, 0, MEN);
    win_a("diff2", 1, 5'b00001, 5'b00011, 5'b10001, 5'b00000, 0, 3, 0, 0);
    ws_a = 1'b1; tick; ws_a = 1'b0;
    nd_a = 1'b1; sp_a = 5'b00001; tick;
    chk("held_step_first", step_a, 1);
    repeat (9) tick;
    chk("held_step_10cyc", step_a, 1);
    nd_a = 1'b0; tick;
    chk("held_step_release", step_a, 1);
    chk("held_busy", busy_a, 1);
    ws_a = 1'b1; nd_a = 1'b1; tick;
    ws_a = 1'b0; nd_a = 1'b0;
    chk("same_cycle_step", step_a, 0);
    tick;
    chk("same_cycle_step2", step_a, 0);
    ws_a = 1'b1; tick; ws_a = 1'b0;
    step_a_t(5'b00010); step_a_t(5'b00010);
    chk("abort_pre_step", step_a, 2);
    ws_a = 1'b1; tick; ws_a = 1'b0;
    chk("abort_step", step_a, 0);
    chk("abort_busy", busy_a, 1);
    win_a("after_abort", 0, 5'b00100, 5'b00100, 5'b00010, 5'b00000, 2, 2, 0, MEN);
    ws_a = 1'b1; tick; ws_a = 1'b0;
    repeat (4) step_a_t(5'b01000);
    v0 = vc_a;
    ws_a = 1'b1; tick; ws_a = 1'b0;
    chk("argmax_abort_step", step_a, 0);
    chk("argmax_abort_busy", busy_a, 1);
    repeat (10) tick;
    chk("argmax_abort_no_valid", vc_a - v0, 0);
    chk("argmax_abort_idx_hold", idx_a, 2);
    ws_b = 1'b1; tick; ws_b = 1'b0;
    repeat (5) step_b_t(5'b00001);
    nd_b = 1'b1; sp_b = 5'b00001; n = 0;
    do begin
      tick; nd_b = 1'b0; n++;
    end while (!cv_b && n < 20);
    chk("sat_latency", n, 6);
    chk("sat_idx", idx_b, 0);
    chk("sat_cnt", cnt_b, 3);
    chk("sat_no_spike", ns_b, 0);
    tick;
    ws_b = 1'b1; tick; ws_b = 1'b0;
    repeat (6) step_b_t(5'b00001);
    chk("rst_argmax_busy_pre", busy_b, 1);
    v0 = vc_b;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_argmax_busy", busy_b, 0);
    chk("rst_argmax_step", step_b, 0);
    chk("rst_argmax_cnt", cnt_b, 0);
    chk("rst_argmax_valid", cv_b, 0);
    chk("rst_async_cnt_a", cnt_a, 0);
    #2 rst_n = 1'b1;
    repeat (12) tick;
    chk("rst_argmax_no_valid", vc_b - v0, 0);
    chk("rst_argmax_idle", busy_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
